rs_hs_pipeline_tail_fifo: RTL and testbench
===========================================

RS_HS_PIPELINE_TAIL_FIFO -- requirements
Module: rs_hs_pipeline_tail_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 24: guaranteed usable entries beyond grace and slack.
REQ-003 SHALL have parameter GRACE_PERIOD, default 17: maximum beats in flight after in_ready deasserts (2*BODY_LEVEL+1).
REQ-004 SHALL have parameter MEM_STYLE, default 0: 0 = registers, 1 = distributed RAM, 2 = block RAM.
REQ-005 SHALL have derived parameter REAL_DEPTH = GRACE_PERIOD + DEPTH + 4, and ADDR_WIDTH = $clog2(REAL_DEPTH).
REQ-006 SHALL have port clk, input, 1: single clock; every register is clocked on its rising edge.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port in_valid, input, 1: beat arriving from the last body stage.
REQ-009 SHALL have port in_data, input, DATA_WIDTH: payload of the arriving beat.
REQ-010 SHALL have port in_ready, output, 1: registered almost-not-full; pipelined back to the head.
REQ-011 SHALL have port out_valid, output, 1: consumer-side valid.
REQ-012 SHALL have port out_data, output, DATA_WIDTH: consumer-side payload.
REQ-013 SHALL have port out_ready, input, 1: consumer-side ready.
REQ-014 SHALL have port overflow_err, output, 1: sticky error flag.
REQ-015 SHALL have port count, output, ADDR_WIDTH+1: current occupancy.

Function
REQ-016 SHALL write in_data whenever in_valid=1 and the FIFO is not full, independent of in_ready; beats still in flight after in_ready falls are absorbed.
REQ-017 SHALL set in_ready, on the clock edge after occupancy changes, to (next count < REAL_DEPTH - GRACE_PERIOD); at defaults the threshold is 28.
REQ-018 SHALL complete a read when out_valid=1 and out_ready=1; out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-019 SHALL present a beat written into an empty FIFO at cycle N with out_valid=1 at cycle N+1, with no combinational in-to-out bypass.
REQ-020 SHALL, on a simultaneous read and write, leave count unchanged; when full, a simultaneous read SHALL allow the write to be accepted.
REQ-021 SHALL, when in_valid=1, the FIFO is full and no read occurs, drop the beat, set overflow_err=1 until reset, and leave pointers unchanged.
REQ-022 SHALL wrap the read and write pointers from REAL_DEPTH-1 to 0, including when REAL_DEPTH is not a power of two.
REQ-023 SHALL derive full as count==REAL_DEPTH and empty as count==0; count SHALL never exceed REAL_DEPTH.
REQ-024 SHALL preserve beat order exactly, with no duplication or loss except per REQ-021.

Reset
REQ-025 SHALL, while reset=0, clear pointers and count to 0, set out_valid=0, overflow_err=0 and in_ready=1; out_data is don't-care.
REQ-026 SHALL, on reset assertion mid-operation, discard all stored beats immediately without waiting for a clock edge.
REQ-027 SHALL apply reset release synchronously; the block SHALL accept a beat on the first rising edge after release.
REQ-028 SHALL reset no memory-array contents.

Structure
REQ-029 SHALL take the grace-period formula function and the MEM_STYLE encodings from shared package rs_hs_pkg.
REQ-030 SHALL place storage in one sub-module, rs_hs_tail_mem: 1 write port, 1 read port, style selected by MEM_STYLE.
REQ-031 SHALL hold occupancy and the handshake and error logic in the top level, with no latches and no combinational path from out_ready to in_ready.

Verification
REQ-032 SHALL cover: write 0xA5 into an empty FIFO at cycle 5 with out_ready=1 -> out_valid=1 and out_data=0xA5 at cycle 6, count back to 0 at cycle 7.
REQ-033 SHALL cover: with out_ready=0, stream 28 beats -> in_ready=0 at the edge after the 28th write; 17 further beats accepted; count=45; overflow_err=0.
REQ-034 SHALL cover: 45 stored, out_ready=0, in_valid=1 -> overflow_err=1, count stays 45, the first 45 values read back intact.
REQ-035 SHALL cover: 45 stored, out_ready=1 and in_valid=1 on the same cycle -> count stays 45, no error, the new beat is read last.
REQ-036 SHALL cover: 200 random beats with random valid and ready -> in-order data, pointers wrap past 44 to 0, in_ready toggles at count 28.
REQ-037 SHALL cover: assert reset mid-stream, between clock edges, with 10 stored -> out_valid=0, count=0 and in_ready=1 immediately.

Source files
------------

// File: rtl/rs_hs_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rs_hs_pkg
// Brief   : Shared constants and helpers for the handshake pipeline tail.
// Revision: 1.0 - initial release
// ============================================================================
package rs_hs_pkg;

    localparam int MEM_STYLE_REGS = 0;
    localparam int MEM_STYLE_DIST = 1;
    localparam int MEM_STYLE_BRAM = 2;

    // Beats that can still arrive after in_ready drops: ready travels back
    // through body_level stages and valid data travels forward through them.
    function automatic int grace_period(input int body_level);
        return 2 * body_level + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rs_hs_tail_mem.sv
`default_nettype none
// ============================================================================
// Module  : rs_hs_tail_mem
// Brief   : 1W/1R storage array for the tail FIFO, style chosen by MEM_STYLE.
// Revision: 1.0 - initial release
// ============================================================================
module rs_hs_tail_mem
    import rs_hs_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ENTRIES    = 45,
    parameter int ADDR_WIDTH = 6,
    parameter int MEM_STYLE  = MEM_STYLE_REGS
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    // Read stays asynchronous in every style so a beat written at cycle N is
    // visible at N+1; the style only steers the synthesis mapping.
    generate
        if (MEM_STYLE == MEM_STYLE_BRAM) begin : g_bram
            (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem_q [ENTRIES];
            always_ff @(posedge clk) begin
                if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
            end
            assign rd_data_o = mem_q[rd_addr_i];
        end else if (MEM_STYLE == MEM_STYLE_DIST) begin : g_dist
            (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] mem_q [ENTRIES];
            always_ff @(posedge clk) begin
                if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
            end
            assign rd_data_o = mem_q[rd_addr_i];
        end else begin : g_regs
            (* ram_style = "registers" *) logic [DATA_WIDTH-1:0] mem_q [ENTRIES];
            always_ff @(posedge clk) begin
                if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
            end
            assign rd_data_o = mem_q[rd_addr_i];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/rs_hs_pipeline_tail_fifo.sv
`default_nettype none
// ============================================================================
// Module  : rs_hs_pipeline_tail_fifo
// Brief   : Skid FIFO at the tail of a pipelined-ready handshake chain.
// Revision: 1.0 - initial release
// ============================================================================
module rs_hs_pipeline_tail_fifo
    import rs_hs_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 24,
    parameter int GRACE_PERIOD = grace_period(8),
    parameter int MEM_STYLE    = MEM_STYLE_REGS,
    localparam int REAL_DEPTH  = GRACE_PERIOD + DEPTH + 4,
    localparam int ADDR_WIDTH  = $clog2(REAL_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  overflow_err,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int                   C_CW     = ADDR_WIDTH + 1;
    localparam logic [C_CW-1:0]       C_FULL   = C_CW'(REAL_DEPTH);
    localparam logic [C_CW-1:0]       C_THRESH = C_CW'(REAL_DEPTH - GRACE_PERIOD);
    localparam logic [ADDR_WIDTH-1:0] C_LAST   = ADDR_WIDTH'(REAL_DEPTH - 1);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [C_CW-1:0]       count_q, count_d;
    logic                  in_ready_q, in_ready_d;
    logic                  ovf_q, ovf_d;
    logic                  w_full, w_empty, w_wr, w_rd;

    always_comb begin
        w_full     = (count_q == C_FULL);
        w_empty    = (count_q == '0);
        w_rd       = !w_empty && out_ready;
        // A read in the same cycle frees the slot the write lands in.
        w_wr       = in_valid && (!w_full || w_rd);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q || (in_valid && w_full && !w_rd);

        if (w_wr) wr_ptr_d = (wr_ptr_q == C_LAST) ? '0 : wr_ptr_q + ADDR_WIDTH'(1);
        if (w_rd) rd_ptr_d = (rd_ptr_q == C_LAST) ? '0 : rd_ptr_q + ADDR_WIDTH'(1);

        case ({w_wr, w_rd})
            2'b10:   count_d = count_q + C_CW'(1);
            2'b01:   count_d = count_q - C_CW'(1);
            default: count_d = count_q;
        endcase

        in_ready_d = (count_d < C_THRESH);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b1;
            ovf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
            ovf_q      <= ovf_d;
        end
    end

    rs_hs_tail_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ENTRIES    (REAL_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_STYLE  (MEM_STYLE)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (w_wr),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (in_data),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (out_data)
    );

    assign out_valid    = !w_empty;
    assign in_ready     = in_ready_q;
    assign overflow_err = ovf_q;
    assign count        = count_q;

endmodule
`default_nettype wire

// File: tb/tb_rs_hs_pipeline_tail_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_rs_hs_pipeline_tail_fifo
// Brief   : Directed and queue-model checks for rs_hs_pipeline_tail_fifo.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rs_hs_pipeline_tail_fifo;

    localparam int C_RD = 45;
    localparam int C_TH = 28;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, overflow_err;
    logic [31:0] out_data;
    logic [6:0]  count;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] q[$];

    rs_hs_pipeline_tail_fifo u_dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .overflow_err (overflow_err),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          acc;
        int          cyc;
        int          guard;
        bit          saw_low;
        bit          rd;
        bit          v;
        bit          fill;
        logic        exp_ir;
        logic [31:0] exp_d;

        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_ovf", 32'(overflow_err), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        tick(); tick();

        // single beat through an empty FIFO
        in_valid = 1'b1; in_data = 32'hA5; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("first_valid", 32'(out_valid), 32'd1);
        check("first_data", out_data, 32'hA5);
        check("first_count", 32'(count), 32'd1);
        tick();
        check("first_drained", 32'(count), 32'd0);
        check("first_empty", 32'(out_valid), 32'd0);

        // fill to threshold, then through the grace window
        out_ready = 1'b0;
        for (int i = 0; i < 28; i++) begin
            in_valid = 1'b1; in_data = 32'(100 + i);
            tick();
            if (i == 26) check("ready_at_27", 32'(in_ready), 32'd1);
        end
        check("ready_low_28", 32'(in_ready), 32'd0);
        check("count_28", 32'(count), 32'd28);
        for (int i = 28; i < 45; i++) begin
            in_data = 32'(100 + i);
            tick();
        end
        in_valid = 1'b0;
        check("count_45", 32'(count), 32'd45);
        check("ovf_after_fill", 32'(overflow_err), 32'd0);
        check("ready_full", 32'(in_ready), 32'd0);

        // full with simultaneous read and write
        in_valid = 1'b1; in_data = 32'hBEEF; out_ready = 1'b1;
        check("full_head", out_data, 32'd100);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        check("rw_full_count", 32'(count), 32'd45);
        check("rw_full_ovf", 32'(overflow_err), 32'd0);

        // full with write and no read: dropped, sticky error
        in_valid = 1'b1; in_data = 32'hDEAD;
        tick();
        in_valid = 1'b0;
        check("ovf_set", 32'(overflow_err), 32'd1);
        check("ovf_count", 32'(count), 32'd45);
        tick();
        check("ovf_sticky", 32'(overflow_err), 32'd1);

        out_ready = 1'b1;
        for (int i = 0; i < 45; i++) begin
            exp_d = (i < 44) ? 32'(101 + i) : 32'hBEEF;
            check("drain_data", out_data, exp_d);
            tick();
        end
        out_ready = 1'b0;
        check("drain_count", 32'(count), 32'd0);
        check("drain_empty", 32'(out_valid), 32'd0);
        check("drain_ovf", 32'(overflow_err), 32'd1);

        // asynchronous reset with 10 stored
        reset = 1'b0; tick(); reset = 1'b1; tick();
        check("ovf_cleared", 32'(overflow_err), 32'd0);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = 32'(500 + i);
            tick();
        end
        in_valid = 1'b0;
        check("count_10", 32'(count), 32'd10);
        #3;
        reset = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_ready", 32'(in_ready), 32'd1);
        #2;
        reset = 1'b1; in_valid = 1'b1; in_data = 32'd77;
        tick();
        in_valid = 1'b0;
        check("post_rst_accept", 32'(count), 32'd1);
        check("post_rst_data", out_data, 32'd77);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_rst_empty", 32'(count), 32'd0);

        // random traffic against a queue model
        acc = 0; cyc = 0; saw_low = 0; exp_ir = 1'b1;
        while (acc < 200 && cyc < 5000) begin
            cyc++;
            fill = ((cyc / 120) % 2) == 0;
            out_ready = fill ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
            v = fill ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
            rd = (q.size() > 0) && out_ready;
            if (q.size() == C_RD && !rd) v = 1'b0;
            in_valid = v;
            in_data  = $urandom;
            check("rnd_valid", 32'(out_valid), 32'(q.size() > 0));
            if (q.size() > 0) check("rnd_data", out_data, q[0]);
            check("rnd_count", 32'(count), 32'(q.size()));
            check("rnd_ready", 32'(in_ready), 32'(exp_ir));
            if (!in_ready) saw_low = 1'b1;
            @(posedge clk);
            if (rd) void'(q.pop_front());
            if (v) begin
                q.push_back(in_data);
                acc++;
            end
            exp_ir = (q.size() < C_TH);
            #1;
        end
        in_valid = 1'b0;
        check("rnd_budget", 32'(acc), 32'd200);
        check("rnd_saw_ready_low", 32'(saw_low), 32'd1);
        check("rnd_ovf", 32'(overflow_err), 32'd0);
        out_ready = 1'b1;
        guard = 0;
        while (q.size() > 0 && guard < 100) begin
            guard++;
            check("rnd_drain", out_data, q[0]);
            tick();
            void'(q.pop_front());
        end
        check("rnd_final_count", 32'(count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
